// File: rtl/rom_sync_loadable.sv
// Loadable program memory with a registered CPU read port and a valid/ready loader.
// Define ROM_PARITY_EN to store an even-parity bit per word and add the parity_err port.
module rom_sync_loadable #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 128,
  parameter int BASE   = 0,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              range_err,
  output logic              busy,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
`ifdef ROM_PARITY_EN
  output logic [CW-1:0]     ld_count,
  output logic              parity_err
`else
  output logic [CW-1:0]     ld_count
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0]   PTR_MAX = CW'(DEPTH - 1);
  localparam logic [ADDR_W:0] WIN_LO  = (ADDR_W + 1)'(BASE);
  localparam logic [ADDR_W:0] WIN_HI  = (ADDR_W + 1)'(BASE + DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic [CW-1:0]     ptr_reg, ptr_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [DATA_W-1:0] data_out_reg;
  logic              data_valid_reg;
  logic              range_err_reg;

  // No reset on the array: the configuration image leaves it all zeros and loads survive reset.
  logic [DATA_W-1:0] mem [DEPTH];

  logic              beat;
  logic              in_win;
  logic [ADDR_W:0]   addr_x;
  logic [IW-1:0]     rd_idx;
  logic [DATA_W-1:0] rd_word;

  assign beat    = (state_reg == LOAD) && ld_valid;
  assign addr_x  = {1'b0, address};
  assign in_win  = (addr_x >= WIN_LO) && (addr_x < WIN_HI);
  assign rd_idx  = IW'(addr_x - WIN_LO);
  assign rd_word = mem[rd_idx];

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    count_next = count_reg;
    unique case (state_reg)
      IDLE: begin
        if (ld_start) begin
          state_next = LOAD;
          ptr_next   = '0;
        end
      end
      LOAD: begin
        if (ld_valid) begin
          ptr_next = ptr_reg + 1'b1;
          if (ld_last || (ptr_reg == PTR_MAX)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        count_next = ptr_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      mem[ptr_reg[IW-1:0]] <= ld_data;
    end
  end

  // Reads are serviced only in IDLE; a refused read still clears the result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      range_err_reg  <= 1'b0;
    end else if (rd_en) begin
      if (state_reg != IDLE) begin
        data_out_reg   <= '0;
        data_valid_reg <= 1'b0;
        range_err_reg  <= 1'b0;
      end else if (in_win) begin
        data_out_reg   <= rd_word;
        data_valid_reg <= 1'b1;
        range_err_reg  <= 1'b0;
      end else begin
        data_out_reg   <= '0;
        data_valid_reg <= 1'b1;
        range_err_reg  <= 1'b1;
      end
    end else begin
      data_valid_reg <= 1'b0;
    end
  end

`ifdef ROM_PARITY_EN
  logic mem_par [DEPTH];
  logic parity_err_reg;
  logic par_bad;

  assign par_bad = mem_par[rd_idx] ^ (^rd_word);

  always_ff @(posedge clk) begin
    if (beat) begin
      mem_par[ptr_reg[IW-1:0]] <= ^ld_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_err_reg <= 1'b0;
    end else if (rd_en) begin
      parity_err_reg <= (state_reg == IDLE) && in_win && par_bad;
    end
  end

  assign parity_err = parity_err_reg;
`endif

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign range_err  = range_err_reg;
  assign busy       = (state_reg != IDLE);
  assign ld_ready   = (state_reg == LOAD);
  assign ld_done    = (state_reg == DONE);
  assign ld_count   = count_reg;

endmodule

// File: tb/tb_rom_sync_loadable.sv
// Directed self-checking bench for rom_sync_loadable: default window instance plus a BASE=0x40 instance.
// Build with ROM_PARITY_EN defined to exercise the parity port as well.
module tb_rom_sync_loadable;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a: BASE=0, DEPTH=128
  logic       reset, rd_en, ld_start, ld_valid, ld_last;
  logic [7:0] address, ld_data;
  logic [7:0] data_out;
  logic       data_valid, range_err, busy, ld_ready, ld_done;
  logic [7:0] ld_count;
  // Instance b: BASE=0x40, DEPTH=128
  logic       b_reset, b_rd_en, b_ld_start, b_ld_valid, b_ld_last;
  logic [7:0] b_address, b_ld_data;
  logic [7:0] b_data_out;
  logic       b_data_valid, b_range_err, b_busy, b_ld_ready, b_ld_done;
  logic [7:0] b_ld_count;
`ifdef ROM_PARITY_EN
  logic       parity_err, b_parity_err;
`endif

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] prog [11];

  rom_sync_loadable #(.DATA_W(8), .ADDR_W(8), .DEPTH(128), .BASE(0)) dut (
    .clk(clk), .reset(reset), .address(address), .rd_en(rd_en),
    .data_out(data_out), .data_valid(data_valid), .range_err(range_err), .busy(busy),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_done(ld_done),
`ifdef ROM_PARITY_EN
    .ld_count(ld_count), .parity_err(parity_err)
`else
    .ld_count(ld_count)
`endif
  );

  rom_sync_loadable #(.DATA_W(8), .ADDR_W(8), .DEPTH(128), .BASE(8'h40)) dut_b (
    .clk(clk), .reset(b_reset), .address(b_address), .rd_en(b_rd_en),
    .data_out(b_data_out), .data_valid(b_data_valid), .range_err(b_range_err), .busy(b_busy),
    .ld_start(b_ld_start), .ld_valid(b_ld_valid), .ld_data(b_ld_data), .ld_last(b_ld_last),
    .ld_ready(b_ld_ready), .ld_done(b_ld_done),
`ifdef ROM_PARITY_EN
    .ld_count(b_ld_count), .parity_err(b_parity_err)
`else
    .ld_count(b_ld_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    n_total++; if (data_out !== 8'h00) $display("FAIL reset_data_out: got %h want 00", data_out); else n_pass++;
    n_total++; if (data_valid !== 1'b0) $display("FAIL reset_data_valid: got %b want 0", data_valid); else n_pass++;
    n_total++; if (range_err !== 1'b0) $display("FAIL reset_range_err: got %b want 0", range_err); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (ld_ready !== 1'b0) $display("FAIL reset_ld_ready: got %b want 0", ld_ready); else n_pass++;
    n_total++; if (ld_done !== 1'b0) $display("FAIL reset_ld_done: got %b want 0", ld_done); else n_pass++;
    n_total++; if (ld_count !== 8'd0) $display("FAIL reset_ld_count: got %0d want 0", ld_count); else n_pass++;
`ifdef ROM_PARITY_EN
    n_total++; if (parity_err !== 1'b0) $display("FAIL reset_parity_err: got %b want 0", parity_err); else n_pass++;
`endif
    reset = 1'b1;
    b_reset = 1'b1;
    tick();
    $display("reset: outputs checked, reset released");
  endtask

  task automatic test_read_zero();
    address = 8'h05; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_total++; if (data_out !== 8'h00) $display("FAIL read0_data: got %h want 00", data_out); else n_pass++;
    n_total++; if (data_valid !== 1'b1) $display("FAIL read0_valid: got %b want 1", data_valid); else n_pass++;
    n_total++; if (range_err !== 1'b0) $display("FAIL read0_rerr: got %b want 0", range_err); else n_pass++;
    tick();
    n_total++; if (data_valid !== 1'b0) $display("FAIL read0_valid_drop: got %b want 0", data_valid); else n_pass++;
    $display("read 0x05 after reset: data=%h valid_then=1", data_out);
  endtask

  task automatic test_load();
    logic [7:0] addrs [4] = '{8'h04, 8'h0B, 8'h00, 8'h0A};
    logic [7:0] exps  [4] = '{8'h42, 8'h00, 8'h88, 8'h08};
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL load_busy: got %b want 1", busy); else n_pass++;
    n_total++; if (ld_ready !== 1'b1) $display("FAIL load_ready: got %b want 1", ld_ready); else n_pass++;
    for (int i = 0; i < 11; i++) begin
      ld_valid = 1'b1; ld_data = prog[i]; ld_last = (i == 10);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    n_total++; if (ld_done !== 1'b1) $display("FAIL load_done_pulse: got %b want 1", ld_done); else n_pass++;
    n_total++; if (ld_ready !== 1'b0) $display("FAIL load_ready_done: got %b want 0", ld_ready); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL load_busy_done: got %b want 1", busy); else n_pass++;
    tick();
    n_total++; if (ld_done !== 1'b0) $display("FAIL load_done_fall: got %b want 0", ld_done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL load_busy_fall: got %b want 0", busy); else n_pass++;
    n_total++; if (ld_count !== 8'd11) $display("FAIL load_count: got %0d want 11", ld_count); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      address = addrs[i]; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      n_total++; if (data_out !== exps[i]) $display("FAIL load_read_%h: got %h want %h", addrs[i], data_out, exps[i]); else n_pass++;
      $display("load read addr=%h data=%h", addrs[i], data_out);
    end
  endtask

  task automatic test_backpressure();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i % 3 == 1) begin
        ld_valid = 1'b0; ld_last = 1'b1; rd_en = 1'b1; address = 8'h04;
        tick();
        rd_en = 1'b0; ld_last = 1'b0;
        n_total++; if (data_valid !== 1'b0) $display("FAIL bp_read_valid_%0d: got %b want 0", i, data_valid); else n_pass++;
        n_total++; if (data_out !== 8'h00) $display("FAIL bp_read_data_%0d: got %h want 00", i, data_out); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL bp_busy_%0d: got %b want 1", i, busy); else n_pass++;
      end
      ld_valid = 1'b1; ld_data = prog[i]; ld_last = (i == 10);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    n_total++; if (ld_done !== 1'b1) $display("FAIL bp_done: got %b want 1", ld_done); else n_pass++;
    tick();
    n_total++; if (ld_count !== 8'd11) $display("FAIL bp_count: got %0d want 11", ld_count); else n_pass++;
    for (int i = 0; i < 11; i++) begin
      address = 8'(i); rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      n_total++; if (data_out !== prog[i]) $display("FAIL bp_word_%0d: got %h want %h", i, data_out, prog[i]); else n_pass++;
    end
    $display("backpressure load: 11 words read back, count=%0d", ld_count);
  endtask

  task automatic test_overflow();
    logic [7:0] addrs [4] = '{8'h00, 8'h7F, 8'h04, 8'h80};
    logic [7:0] exps  [4] = '{8'hA4, 8'h25, 8'hA0, 8'h00};
    logic       errs  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int k = 1; k <= 130; k++) begin
      ld_valid = 1'b1; ld_data = 8'(k) ^ 8'hA5; ld_last = 1'b0;
      if (k >= 129) begin
        n_total++; if (ld_ready !== 1'b0) $display("FAIL ovf_ready_beat%0d: got %b want 0", k, ld_ready); else n_pass++;
      end
      if (k == 129) begin
        n_total++; if (ld_done !== 1'b1) $display("FAIL ovf_done: got %b want 1", ld_done); else n_pass++;
      end
      tick();
    end
    ld_valid = 1'b0;
    n_total++; if (ld_count !== 8'd128) $display("FAIL ovf_count: got %0d want 128", ld_count); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL ovf_busy: got %b want 0", busy); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      address = addrs[i]; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      n_total++; if (data_out !== exps[i]) $display("FAIL ovf_read_%h: got %h want %h", addrs[i], data_out, exps[i]); else n_pass++;
      n_total++; if (range_err !== errs[i]) $display("FAIL ovf_rerr_%h: got %b want %b", addrs[i], range_err, errs[i]); else n_pass++;
      $display("overflow read addr=%h data=%h rerr=%b", addrs[i], data_out, range_err);
    end
  endtask

  task automatic test_window();
    logic [7:0] addrs [4] = '{8'h40, 8'h3F, 8'hBF, 8'hC0};
    logic [7:0] exps  [4] = '{8'h5A, 8'h00, 8'h00, 8'h00};
    logic       errs  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    b_ld_start = 1'b1;
    tick();
    b_ld_start = 1'b0;
    b_ld_valid = 1'b1; b_ld_data = 8'h5A; b_ld_last = 1'b1;
    tick();
    b_ld_valid = 1'b0; b_ld_last = 1'b0;
    tick();
    n_total++; if (b_ld_count !== 8'd1) $display("FAIL win_count: got %0d want 1", b_ld_count); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      b_address = addrs[i]; b_rd_en = 1'b1;
      tick();
      b_rd_en = 1'b0;
      n_total++; if (b_data_out !== exps[i]) $display("FAIL win_data_%h: got %h want %h", addrs[i], b_data_out, exps[i]); else n_pass++;
      n_total++; if (b_range_err !== errs[i]) $display("FAIL win_rerr_%h: got %b want %b", addrs[i], b_range_err, errs[i]); else n_pass++;
      n_total++; if (b_data_valid !== 1'b1) $display("FAIL win_valid_%h: got %b want 1", addrs[i], b_data_valid); else n_pass++;
      $display("window read addr=%h data=%h rerr=%b", addrs[i], b_data_out, b_range_err);
    end
    tick();
    n_total++; if (b_range_err !== 1'b1) $display("FAIL win_rerr_hold: got %b want 1", b_range_err); else n_pass++;
    n_total++; if (b_data_valid !== 1'b0) $display("FAIL win_valid_idle: got %b want 0", b_data_valid); else n_pass++;
  endtask

  task automatic test_same_edge();
    address = 8'h04; rd_en = 1'b1; ld_start = 1'b1;
    tick();
    rd_en = 1'b0; ld_start = 1'b0;
    n_total++; if (data_valid !== 1'b1) $display("FAIL same_valid: got %b want 1", data_valid); else n_pass++;
    n_total++; if (data_out !== 8'hA0) $display("FAIL same_data: got %h want a0", data_out); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL same_busy: got %b want 1", busy); else n_pass++;
    $display("read+ld_start same edge: data=%h busy=%b", data_out, busy);
  endtask

  task automatic test_reset_midload();
    logic [7:0] exps [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hA3};
    for (int k = 0; k < 5; k++) begin
      ld_valid = 1'b1; ld_data = 8'(8'h11 * (k + 1)); ld_last = 1'b0;
      tick();
    end
    ld_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    n_total++; if (data_out !== 8'h00) $display("FAIL mid_data_out: got %h want 00", data_out); else n_pass++;
    n_total++; if (data_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", data_valid); else n_pass++;
    n_total++; if (range_err !== 1'b0) $display("FAIL mid_rerr: got %b want 0", range_err); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (ld_ready !== 1'b0) $display("FAIL mid_ready: got %b want 0", ld_ready); else n_pass++;
    n_total++; if (ld_done !== 1'b0) $display("FAIL mid_done: got %b want 0", ld_done); else n_pass++;
    n_total++; if (ld_count !== 8'd0) $display("FAIL mid_count: got %0d want 0", ld_count); else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    n_total++; if (ld_done !== 1'b0) $display("FAIL mid_no_done: got %b want 0", ld_done); else n_pass++;
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL mid_idle: got %b want 0", busy); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      address = 8'(i); rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      n_total++; if (data_out !== exps[i]) $display("FAIL mid_word_%0d: got %h want %h", i, data_out, exps[i]); else n_pass++;
      $display("after mid-load reset read addr=%h data=%h", 8'(i), data_out);
    end
`ifdef ROM_PARITY_EN
    address = 8'h02; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_total++; if (parity_err !== 1'b0) $display("FAIL par_clean: got %b want 0", parity_err); else n_pass++;
    dut.mem[2] = dut.mem[2] ^ 8'h08;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_total++; if (parity_err !== 1'b1) $display("FAIL par_flip: got %b want 1", parity_err); else n_pass++;
    n_total++; if (data_out !== 8'h3B) $display("FAIL par_flip_data: got %h want 3b", data_out); else n_pass++;
    address = 8'h03; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_total++; if (parity_err !== 1'b0) $display("FAIL par_other: got %b want 0", parity_err); else n_pass++;
    $display("parity flip on word 2 checked");
`endif
  endtask

  initial begin
    prog = '{8'h88, 8'h0A, 8'h86, 8'h05, 8'h42, 8'h96, 8'h00, 8'h80, 8'h20, 8'h00, 8'h08};
    reset = 1'b0; rd_en = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    address = 8'h00; ld_data = 8'h00;
    b_reset = 1'b0; b_rd_en = 1'b0; b_ld_start = 1'b0; b_ld_valid = 1'b0; b_ld_last = 1'b0;
    b_address = 8'h00; b_ld_data = 8'h00;
    test_reset();
    test_read_zero();
    test_load();
    test_backpressure();
    test_overflow();
    test_window();
    test_same_edge();
    test_reset_midload();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
